key_capture_register: RTL and testbench

Upstream input stage for the 16-bit display path. It debounces one active-low pushbutton and, on each accepted press, registers the switch word into a holding register. It presents that word, plus a one-cycle load strobe, to the seven-segment decode stage. This replaces raw-key clocking of the data register with a single-clock, debounced, synchronous capture.

---
 rtl/key_capture_pkg.sv | 18 +
 rtl/key_capture_register_sync_2ff.sv | 37 +++
 rtl/key_capture_register.sv | 131 +++++++++++++
 tb/tb_key_capture_register.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// Shared types and defaults for the key capture input stage.
//   - key_state_e: debounce FSM states
//   - DEBOUNCE_CYCLES_DEFAULT / CAPTURE_WIDTH_DEFAULT: parameter defaults
//   - COUNT_W: width of the accepted-press counter
package key_capture_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;
  localparam int unsigned CAPTURE_WIDTH_DEFAULT   = 16;
  localparam int unsigned COUNT_W                 = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

endpackage : key_capture_pkg

// File: rtl/key_capture_register_sync_2ff.sv
// Two-stage 1-bit synchronizer. Both stages reset to 1, the idle level of an
// active-low key, so reset never looks like a press.
// Ports:
//   clk   in  system clock
//   reset in  asynchronous active-high reset
//   d     in  asynchronous input
//   q     out synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/key_capture_register.sv
// Debounced pushbutton capture of a switch word for the display path.
// Each accepted press latches sw into data_q, pulses load_pulse for one
// cycle and bumps capture_count. Build option: define KEY_CAPTURE_SYNC_EN to
// route key_n through a 2-flop synchronizer (adds 2 cycles of latency).
// Ports:
//   clk           in  system clock
//   reset         in  asynchronous active-high reset
//   key_n         in  raw pushbutton, active-low
//   sw            in  switch word, sampled on capture only
//   data_q        out last captured word
//   load_pulse    out one-cycle strobe after each capture
//   held          out debounced key is pressed (HELD / RELEASE_WAIT)
//   capture_count out accepted presses, wraps at 256
module key_capture_register
  import key_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = CAPTURE_WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n,
  input  logic [WIDTH-1:0]   sw,
  output logic [WIDTH-1:0]   data_q,
  output logic               load_pulse,
  output logic               held,
  output logic [COUNT_W-1:0] capture_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic key_s;

`ifdef KEY_CAPTURE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );
`else
  assign key_s = key_n;
`endif

  key_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_d;
  logic               load_pulse_q, load_pulse_d;
  logic               held_q, held_d;
  logic [COUNT_W-1:0] capture_count_q, capture_count_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      data_q          <= '0;
      load_pulse_q    <= 1'b0;
      held_q          <= 1'b0;
      capture_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      data_q          <= data_d;
      load_pulse_q    <= load_pulse_d;
      held_q          <= held_d;
      capture_count_q <= capture_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s)                 state_d = IDLE;
        else if (cnt_q == CNT_MAX) state_d = HELD;
      end
      HELD: begin
        if (key_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s)                state_d = HELD;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce counter, capture and registered outputs
  always_comb begin
    cnt_d           = cnt_q;
    data_d          = data_q;
    load_pulse_d    = 1'b0;
    capture_count_d = capture_count_q;
    // Registered copy of "next state is a pressed state" keeps held flop-driven
    held_d          = (state_d == HELD) || (state_d == RELEASE_WAIT);
    case (state_q)
      IDLE: begin
        if (!key_s) cnt_d = '0;
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          if (cnt_q == CNT_MAX) begin
            data_d          = sw;
            load_pulse_d    = 1'b1;
            capture_count_d = capture_count_q + COUNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HELD: begin
        if (key_s) cnt_d = '0;
      end
      RELEASE_WAIT: begin
        if (key_s && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
      end
      default: cnt_d = '0;
    endcase
  end

  assign load_pulse    = load_pulse_q;
  assign held          = held_q;
  assign capture_count = capture_count_q;

endmodule : key_capture_register

// File: tb/tb_key_capture_register.sv
// Self-checking bench for key_capture_register (DEBOUNCE_CYCLES=4, WIDTH=16,
// default build without the synchronizer).
module tb_key_capture_register;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_n;
  logic [W-1:0]  sw;
  logic [W-1:0]  data_q;
  logic          load_pulse;
  logic          held;
  logic [7:0]    capture_count;

  int checks   = 0;
  int failures = 0;

  key_capture_register #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_n         (key_n),
    .sw            (sw),
    .data_q        (data_q),
    .load_pulse    (load_pulse),
    .held          (held),
    .capture_count (capture_count)
  );

  always #5 clk = ~clk;

  // Reference model: a press (release) is accepted after D+1 consecutive
  // samples opposite to the current debounced level.
  bit          m_pressed;
  int          m_run;
  logic [W-1:0] m_data;
  int          m_cnt;
  bit          m_load;

  function automatic void model_reset();
    m_pressed = 0; m_run = 0; m_data = '0; m_cnt = 0; m_load = 0;
  endfunction

  function automatic void model_step(logic k, logic [W-1:0] s);
    bit opp;
    m_load = 0;
    opp = m_pressed ? (k == 1'b1) : (k == 1'b0);
    m_run = opp ? m_run + 1 : 0;
    if (m_run == int'(D) + 1) begin
      m_pressed = !m_pressed;
      m_run = 0;
      if (m_pressed) begin
        m_load = 1;
        m_data = s;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs after the edge
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step(key_n, sw);
    #1;
    chk("model_load_pulse",    32'(load_pulse),    32'(m_load));
    chk("model_held",          32'(held),          32'(m_pressed));
    chk("model_data_q",        32'(data_q),        32'(m_data));
    chk("model_capture_count", 32'(capture_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic         key_n;
    logic [W-1:0] sw;
    logic         load;
    logic         held;
    logic [W-1:0] data;
    logic [7:0]   cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic k, logic [W-1:0] s, logic l, logic h,
                              logic [W-1:0] d, logic [7:0] c);
    for (int i = 0; i < n; i++) vecs.push_back('{k, s, l, h, d, c});
  endfunction

  initial begin
    int first_load;
    int loads;
    int start_cnt;
    int run_left;
    logic rkey;

    reset = 1'b1; key_n = 1'b1; sw = '0;
    model_reset();
    tick(); tick();
    chk("reset_data_q",        32'(data_q),        32'h0);
    chk("reset_load_pulse",    32'(load_pulse),    32'h0);
    chk("reset_held",          32'(held),          32'h0);
    chk("reset_capture_count", 32'(capture_count), 32'h0);
    #2 reset = 1'b0;

    // Clean press, release, press bounce, second press with sw change,
    // release bounce
    add(4, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 8'd0);
    add(1, 1'b0, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 8'd1);
    add(5, 1'b0, 16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 8'd1);
    add(4, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 8'd1);
    add(1, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 8'd1);
    add(3, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 8'd1);
    add(2, 1'b1, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 8'd1);
    add(4, 1'b0, 16'h1234, 1'b0, 1'b0, 16'hBEEF, 8'd1);
    add(1, 1'b0, 16'h1234, 1'b1, 1'b1, 16'h1234, 8'd2);
    add(3, 1'b0, 16'h5678, 1'b0, 1'b1, 16'h1234, 8'd2);
    add(2, 1'b1, 16'h5678, 1'b0, 1'b1, 16'h1234, 8'd2);
    add(1, 1'b0, 16'h5678, 1'b0, 1'b1, 16'h1234, 8'd2);
    add(4, 1'b1, 16'h5678, 1'b0, 1'b1, 16'h1234, 8'd2);
    add(1, 1'b1, 16'h5678, 1'b0, 1'b0, 16'h1234, 8'd2);

    foreach (vecs[i]) begin
      key_n = vecs[i].key_n;
      sw    = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d_load_pulse", i),    32'(load_pulse),    32'(vecs[i].load));
      chk($sformatf("vec%0d_held", i),          32'(held),          32'(vecs[i].held));
      chk($sformatf("vec%0d_data_q", i),        32'(data_q),        32'(vecs[i].data));
      chk($sformatf("vec%0d_capture_count", i), 32'(capture_count), 32'(vecs[i].cnt));
    end

    // Async reset in the middle of PRESS_WAIT, key kept low through release
    key_n = 1'b0; sw = 16'hABCD;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_rst_data_q",        32'(data_q),        32'h0);
    chk("async_rst_load_pulse",    32'(load_pulse),    32'h0);
    chk("async_rst_held",          32'(held),          32'h0);
    chk("async_rst_capture_count", 32'(capture_count), 32'h0);
    #2 reset = 1'b0;
    first_load = 0;
    for (int e = 1; e <= 20 && first_load == 0; e++) begin
      tick();
      if (load_pulse) first_load = e;
    end
    chk("post_reset_capture_edge", 32'(first_load), 32'd5);
    chk("post_reset_data_q",       32'(data_q),     32'hABCD);

    // 256 clean press/release cycles wrap the counter back to its start value
    key_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    start_cnt = m_cnt;
    loads = 0;
    for (int p = 0; p < 256; p++) begin
      sw = W'(p);
      key_n = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); if (load_pulse) loads++; end
      key_n = 1'b1;
      for (int i = 0; i < 6; i++) begin tick(); if (load_pulse) loads++; end
    end
    chk("wrap_load_count",    32'(loads),         32'd256);
    chk("wrap_capture_count", 32'(capture_count), 32'(start_cnt));

    // Random bouncing key with random switches and occasional async resets
    run_left = 0;
    rkey = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        rkey = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 8));
      end
      run_left--;
      key_n = rkey;
      sw = W'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rand_rst_load_pulse", 32'(load_pulse), 32'h0);
        chk("rand_rst_held",       32'(held),       32'h0);
        #2 reset = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_key_capture_register
